// File: rtl/calc_uart_sequencer_if.sv
// Byte-stream bus between the calculator sequencer and its UART rx/tx
// neighbours plus the display readout.
interface calc_uart_sequencer_if #(
  parameter int OP_W = 16
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            back;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [OP_W-1:0] result;
  logic            error;
  logic            done;
  logic [2:0]      stat;

  // Environment side: UART rx/tx models, back button, display.
  modport master (
    output rx_data, rx_valid, back, tx_busy,
    input  tx_start, tx_data, result, error, done, stat
  );

  // Sequencer side.
  modport slave (
    input  rx_data, rx_valid, back, tx_busy,
    output tx_start, tx_data, result, error, done, stat
  );
endinterface

// File: rtl/calc_uart_sequencer.sv
// Calculator byte sequencer: collects op1, op2 and an opcode from UART
// rx bytes, runs one ALU operation and streams the result MSB-first.
module calc_uart_sequencer #(
  parameter int OP_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  calc_uart_sequencer_if.slave  bus
);
  localparam int BYTES = OP_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    WAIT_OP1 = 3'd0,
    WAIT_OP2 = 3'd1,
    WAIT_CMD = 3'd2,
    EXEC     = 3'd3,
    SEND     = 3'd4,
    TX_WAIT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OP_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [OP_W-1:0] result_q, result_d;
  logic [7:0]      opc_q, opc_d;
  logic            error_q, error_d;
  logic            done_q, done_d;
  logic            opc_ok;
  logic [OP_W-1:0] alu_res;
  logic [7:0]      tx_byte;

  // Opcode recognition for the incoming command byte.
  always_comb begin
    opc_ok = 1'b0;
    case (bus.rx_data)
      8'h2B, 8'h2D, 8'h2A, 8'h26, 8'h7C: opc_ok = 1'b1;
      default:                           opc_ok = 1'b0;
    endcase
  end

  // ALU on the latched opcode; all results wrap to OP_W bits.
  always_comb begin
    alu_res = '0;
    case (opc_q)
      8'h2B:   alu_res = op1_q + op2_q;
      8'h2D:   alu_res = op1_q - op2_q;
      8'h2A:   alu_res = op1_q * op2_q;
      8'h26:   alu_res = op1_q & op2_q;
      8'h7C:   alu_res = op1_q | op2_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic; back beats rx_valid, bytes outside entry states drop.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opc_d    = opc_q;
    result_d = result_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      WAIT_OP1: begin
        if (bus.back) begin
          idx_d = '0;
        end else if (bus.rx_valid) begin
          op1_d = (op1_q << 8) | OP_W'(bus.rx_data);
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = WAIT_OP2;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_OP2: begin
        if (bus.back) begin
          idx_d   = '0;
          state_d = WAIT_OP1;
        end else if (bus.rx_valid) begin
          op2_d = (op2_q << 8) | OP_W'(bus.rx_data);
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = WAIT_CMD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_CMD: begin
        if (bus.back) begin
          idx_d   = '0;
          error_d = 1'b0;
          state_d = WAIT_OP2;
        end else if (bus.rx_valid) begin
          if (opc_ok) begin
            opc_d   = bus.rx_data;
            error_d = 1'b0;
            state_d = EXEC;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      EXEC: begin
        result_d = alu_res;
        idx_d    = '0;
        state_d  = SEND;
      end
      // idx carries across SEND/TX_WAIT: it counts bytes of one result.
      SEND: begin
        if (!bus.tx_busy) state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!bus.tx_busy) begin
          if (idx_q != LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end else begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = WAIT_OP1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = WAIT_OP1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_OP1;
      idx_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      opc_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opc_q    <= opc_d;
      result_q <= result_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  // Result byte for the current send index, MSB first.
  always_comb begin
    tx_byte = result_q[8*(BYTES-1-int'(idx_q)) +: 8];
  end

  assign bus.tx_start = (state_q == SEND) && !bus.tx_busy;
  assign bus.tx_data  = (state_q == SEND || state_q == TX_WAIT) ? tx_byte : 8'h00;
  assign bus.result   = result_q;
  assign bus.error    = error_q;
  assign bus.done     = done_q;
  assign bus.stat     = state_q;
endmodule

// File: tb/tb_calc_uart_sequencer.sv
// Scoreboard bench for calc_uart_sequencer (OP_W=16): expected tx bytes are
// queued as each frame is issued and checked by a transmitter model.
module tb_calc_uart_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic tb_hold = 1'b0;
  logic tx_active = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tx_cnt = 0;
  logic [7:0] exp_q[$];

  calc_uart_sequencer_if #(.OP_W(16)) ifc ();
  assign ifc.tx_busy = tb_hold | tx_active;

  calc_uart_sequencer #(.OP_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Transmitter model: pops the expected byte on every tx_start and stays
  // busy for three cycles starting the cycle after the request.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk); #1;
      if (ifc.tx_start === 1'b1) begin
        tx_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: tx_start with data %h, none expected", ifc.tx_data);
        end else begin
          e = exp_q.pop_front();
          if (ifc.tx_data !== e) begin
            n_err++;
            $display("FAIL tx_data: got %h expected %h", ifc.tx_data, e);
          end
        end
        @(posedge clk); #1 tx_active = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_active = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic with_back = 1'b0);
    @(negedge clk);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    ifc.back     = with_back;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.back     = 1'b0;
  endtask

  task automatic pulse_back();
    @(negedge clk);
    ifc.back = 1'b1;
    @(negedge clk);
    ifc.back = 1'b0;
  endtask

  task automatic send_ops(input logic [15:0] a, input logic [15:0] b);
    send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(b[15:8]); send_byte(b[7:0]);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (ifc.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_stat(input logic [2:0] s, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (ifc.stat === s) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (ifc.stat !== 3'd0)     begin n_err++; $display("FAIL rst_stat: got %0d expected 0", ifc.stat); end
    n_cmp++; if (ifc.result !== 16'h0)  begin n_err++; $display("FAIL rst_result: got %h expected 0000", ifc.result); end
    n_cmp++; if (ifc.error !== 1'b0)    begin n_err++; $display("FAIL rst_error: got %b expected 0", ifc.error); end
    n_cmp++; if (ifc.done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b expected 0", ifc.done); end
    n_cmp++; if (ifc.tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b expected 0", ifc.tx_start); end
    n_cmp++; if (ifc.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", ifc.tx_data); end
  endtask

  task automatic test_add();
    bit seen;
    int c0;
    c0 = tx_cnt;
    send_ops(16'h1234, 16'h0005);
    exp_q.push_back(8'h12); exp_q.push_back(8'h39);
    send_byte(8'h2B);
    #1;
    n_cmp++; if (ifc.stat !== 3'd3) begin n_err++; $display("FAIL add_exec: got stat %0d expected 3", ifc.stat); end
    @(negedge clk); #1;
    n_cmp++; if (ifc.stat !== 3'd4) begin n_err++; $display("FAIL add_send: got stat %0d expected 4", ifc.stat); end
    n_cmp++; if (ifc.result !== 16'h1239) begin n_err++; $display("FAIL add_result_early: got %h expected 1239", ifc.result); end
    n_cmp++; if (ifc.tx_start !== 1'b1) begin n_err++; $display("FAIL add_first_start: got %b expected 1", ifc.tx_start); end
    wait_done(seen);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL add_done: got no done expected pulse"); end
    n_cmp++; if (ifc.stat !== 3'd0) begin n_err++; $display("FAIL add_stat: got %0d expected 0", ifc.stat); end
    n_cmp++; if (tx_cnt - c0 != 2) begin n_err++; $display("FAIL add_tx_count: got %0d expected 2", tx_cnt - c0); end
    @(negedge clk); #1;
    n_cmp++; if (ifc.done !== 1'b0) begin n_err++; $display("FAIL add_done_width: got %b expected 0", ifc.done); end
  endtask

  task automatic test_wrap_mul();
    bit seen;
    send_ops(16'h0000, 16'h0001);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    send_byte(8'h2D);
    wait_done(seen);
    n_cmp++; if (!seen || ifc.result !== 16'hFFFF) begin n_err++; $display("FAIL sub_wrap: got %h done %b expected FFFF", ifc.result, seen); end
    send_ops(16'h0100, 16'h0100);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    send_byte(8'h2A);
    wait_done(seen);
    n_cmp++; if (!seen || ifc.result !== 16'h0000) begin n_err++; $display("FAIL mul_trunc: got %h done %b expected 0000", ifc.result, seen); end
    send_ops(16'h0F00, 16'h00F0);
    exp_q.push_back(8'h0F); exp_q.push_back(8'hF0);
    send_byte(8'h7C);
    wait_done(seen);
    n_cmp++; if (!seen || ifc.result !== 16'h0FF0) begin n_err++; $display("FAIL or_op: got %h done %b expected 0FF0", ifc.result, seen); end
  endtask

  task automatic test_invalid();
    bit seen;
    int c0;
    c0 = tx_cnt;
    send_ops(16'hF0F0, 16'h0FF0);
    send_byte(8'h41);
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (ifc.error !== 1'b1) begin n_err++; $display("FAIL inv_error: got %b expected 1", ifc.error); end
    n_cmp++; if (ifc.stat !== 3'd2) begin n_err++; $display("FAIL inv_stat: got %0d expected 2", ifc.stat); end
    n_cmp++; if (tx_cnt != c0) begin n_err++; $display("FAIL inv_no_tx: got %0d starts expected 0", tx_cnt - c0); end
    n_cmp++; if (ifc.result !== 16'h0FF0) begin n_err++; $display("FAIL inv_result_held: got %h expected 0FF0", ifc.result); end
    exp_q.push_back(8'h00); exp_q.push_back(8'hF0);
    send_byte(8'h26);
    #1;
    n_cmp++; if (ifc.error !== 1'b0) begin n_err++; $display("FAIL and_error_clr: got %b expected 0", ifc.error); end
    wait_done(seen);
    n_cmp++; if (!seen || ifc.result !== 16'h00F0) begin n_err++; $display("FAIL and_result: got %h done %b expected 00F0", ifc.result, seen); end
  endtask

  task automatic test_back();
    bit seen;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    pulse_back();
    #1;
    n_cmp++; if (ifc.stat !== 3'd0) begin n_err++; $display("FAIL back_op2: got stat %0d expected 0", ifc.stat); end
    send_byte(8'h11, 1'b1);
    #1;
    n_cmp++; if (ifc.stat !== 3'd0) begin n_err++; $display("FAIL back_rx_stat: got %0d expected 0", ifc.stat); end
    // Back from WAIT_CMD clears error and re-enters op2 entry.
    send_ops(16'h0007, 16'h0099);
    send_byte(8'h55);
    pulse_back();
    #1;
    n_cmp++; if (ifc.stat !== 3'd1 || ifc.error !== 1'b0) begin n_err++; $display("FAIL back_cmd: got stat %0d err %b expected 1/0", ifc.stat, ifc.error); end
    send_byte(8'h00); send_byte(8'h03);
    exp_q.push_back(8'h00); exp_q.push_back(8'h15);
    send_byte(8'h2A);
    wait_done(seen);
    n_cmp++; if (!seen || ifc.result !== 16'h0015) begin n_err++; $display("FAIL back_frame: got %h done %b expected 0015", ifc.result, seen); end
  endtask

  task automatic test_stall();
    bit seen;
    int c0;
    logic started;
    c0 = tx_cnt;
    started = 1'b0;
    tb_hold = 1'b1;
    send_ops(16'h8000, 16'h8001);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    send_byte(8'h2B);
    wait_stat(3'd4, seen);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL stall_enter: got stat %0d expected 4", ifc.stat); end
    repeat (10) begin
      @(negedge clk); #1;
      if (ifc.tx_start !== 1'b0) started = 1'b1;
    end
    n_cmp++; if (started || tx_cnt != c0) begin n_err++; $display("FAIL stall_no_start: got start %b expected 0", started); end
    n_cmp++; if (ifc.stat !== 3'd4) begin n_err++; $display("FAIL stall_stat: got %0d expected 4", ifc.stat); end
    @(negedge clk);
    tb_hold = 1'b0;
    wait_done(seen);
    n_cmp++; if (!seen || tx_cnt - c0 != 2) begin n_err++; $display("FAIL stall_release: got %0d starts done %b expected 2", tx_cnt - c0, seen); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int c0;
    send_ops(16'hABCD, 16'h0001);
    exp_q.push_back(8'hAB); exp_q.push_back(8'hCE);
    send_byte(8'h2B);
    wait_stat(3'd5, seen);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL mid_tx_wait: got stat %0d expected 5", ifc.stat); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (ifc.stat !== 3'd0 || ifc.result !== 16'h0) begin n_err++; $display("FAIL mid_rst_state: got stat %0d result %h expected 0/0000", ifc.stat, ifc.result); end
    n_cmp++; if (ifc.tx_data !== 8'h00 || ifc.tx_start !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx: got data %h start %b expected 00/0", ifc.tx_data, ifc.tx_start); end
    n_cmp++; if (ifc.error !== 1'b0 || ifc.done !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got err %b done %b expected 0/0", ifc.error, ifc.done); end
    reset = 1'b0;
    exp_q.delete();
    c0 = tx_cnt;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++; if (tx_cnt != c0 || ifc.stat !== 3'd0) begin n_err++; $display("FAIL mid_rst_quiet: got %0d starts stat %0d expected 0/0", tx_cnt - c0, ifc.stat); end
  endtask

  initial begin
    reset        = 1'b1;
    ifc.rx_data  = 8'h00;
    ifc.rx_valid = 1'b0;
    ifc.back     = 1'b0;
    test_reset();
    test_add();
    test_wrap_mul();
    test_invalid();
    test_back();
    test_stall();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_bytes: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
